// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
//   Four-digit BCD up/down counter feeding a time-multiplexed common-anode
//   display through an external BCD-to-7-segment decoder. Each digit position
//   is selected for SCAN_DIV clock cycles in turn (units first). Leading zeros
//   can be blanked through the decoder's active-low enable.
//
// Parameters
//   SCAN_DIV  clk cycles each digit stays selected (2 .. 2^20)
//   BLANK_LZ  1 = blank leading zeros, 0 = always show all four digits
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear of the count (highest priority)
//   load      synchronous load of load_val (rejected if any nibble > 9)
//   load_val  four BCD nibbles, [15:12] thousands .. [3:0] units
//   cnt_en    count one step this cycle
//   up        1 = increment, 0 = decrement
//   disp_en   0 = all digits dark
//   count     current BCD count (registered)
//   carry     one-cycle pulse on wrap in either direction (registered)
//   load_err  one-cycle pulse when a load is rejected (registered)
//   digit     BCD nibble of the selected digit, to the decoder input
//   n_en      active-low decoder enable, 1 = blank
//   an_n      active-low digit select, bit i = digit i (0 = units)
// -----------------------------------------------------------------------------
module bcd_scan_counter #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        cnt_en,
    input  logic        up,
    input  logic        disp_en,
    output logic [15:0] count,
    output logic        carry,
    output logic        load_err,
    output logic [3:0]  digit,
    output logic        n_en,
    output logic [3:0]  an_n
);

    localparam int unsigned      DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // True when every nibble of v is a legal BCD digit.
    function automatic logic bcd_valid(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // One BCD step; bit 16 is set when the step ripples out of the thousands
    // digit, i.e. on 9999->0000 (inc) or 0000->9999 (dec).
    function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic inc);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (inc) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                        c           = 1'b1;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c           = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                        c           = 1'b1;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        c           = 1'b0;
                    end
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return {c, r};
    endfunction

    logic [15:0]      count_q,    count_d;
    logic             carry_q,    carry_d;
    logic             load_err_q, load_err_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [1:0]       idx_q,      idx_d;
    logic [16:0]      step_s;
    logic [3:0]       digit_s;
    logic             upper_zero_s;

    // Counter next state: clr beats load beats cnt_en; a rejected load also
    // swallows any cnt_en in the same cycle.
    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        step_s     = bcd_step(count_q, up);
        if (clr) begin
            count_d = 16'h0000;
        end else if (load) begin
            if (bcd_valid(load_val)) begin
                count_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (cnt_en) begin
            count_d = step_s[15:0];
            carry_d = step_s[16];
        end else begin
            count_d = count_q;
        end
    end

    // Scan divider and digit index; free-running regardless of display state.
    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
            idx_d = idx_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 16'h0000;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
            div_q      <= '0;
            idx_q      <= 2'd0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
        end
    end

    // Digit mux and "this nibble and all above it are zero" detect.
    always_comb begin
        digit_s      = 4'h0;
        upper_zero_s = 1'b0;
        case (idx_q)
            2'd0: begin
                digit_s      = count_q[3:0];
                upper_zero_s = 1'b0;   // units are never blanked
            end
            2'd1: begin
                digit_s      = count_q[7:4];
                upper_zero_s = (count_q[15:4] == 12'h000);
            end
            2'd2: begin
                digit_s      = count_q[11:8];
                upper_zero_s = (count_q[15:8] == 8'h00);
            end
            2'd3: begin
                digit_s      = count_q[15:12];
                upper_zero_s = (count_q[15:12] == 4'h0);
            end
            default: begin
                digit_s      = 4'h0;
                upper_zero_s = 1'b0;
            end
        endcase
    end

    // Display outputs are combinational from registered state so a count
    // change shows up on digit in the same cycle count updates.
    assign digit    = digit_s;
    assign an_n     = disp_en ? ~(4'b0001 << idx_q) : 4'b1111;
    assign n_en     = ~disp_en | (BLANK_LZ & upper_zero_s);
    assign count    = count_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;

endmodule
